// File: rtl/joystick_spi.sv
// joystick_spi: polls a joystick over SPI mode 0 and publishes X/Y position and buttons.
// Optional macro JSTK_LED_EN: send the led bits in byte 0 instead of holding mosi low.
module joystick_spi #(
   parameter int HALF_DIV = 40,
   parameter int SS_SETUP = 1040,
   parameter int BYTE_GAP = 650,
   parameter int POLL_DIV = 650000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       miso,
   input  logic [1:0] led,
   output logic       sclk,
   output logic       mosi,
   output logic       ss,
   output logic [9:0] Data_out_X,
   output logic [9:0] Data_out_Y,
   output logic [2:0] buttons,
   output logic       data_valid,
   output logic       busy
);
   localparam int TMAX = SS_SETUP > BYTE_GAP ? (SS_SETUP > HALF_DIV ? SS_SETUP : HALF_DIV)
                                             : (BYTE_GAP > HALF_DIV ? BYTE_GAP : HALF_DIV);
   localparam int CW = $clog2(TMAX);
   localparam int PW = $clog2(POLL_DIV);
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;
   state_t        state_q, state_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d, byte_q, byte_d;
   logic          sclk_q, sclk_d, ss_q, ss_d, valid_q, valid_d;
   logic [39:0]   sh_q, sh_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic [2:0]    btn_q, btn_d;
   logic          tick, half_end;
   always_comb begin
      tick = poll_q == '0;
      half_end = cnt_q == CW'(HALF_DIV - 1);
      poll_d = poll_q == PW'(POLL_DIV - 1) ? '0 : poll_q + 1'b1;
      state_d = state_q;
      cnt_d = cnt_q + 1'b1;
      bit_d = bit_q;
      byte_d = byte_q;
      sclk_d = sclk_q;
      ss_d = ss_q;
      sh_d = sh_q;
      x_d = x_q;
      y_d = y_q;
      btn_d = btn_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: if (tick) begin
            state_d = SETUP;
            ss_d = 1'b0;
            cnt_d = '0;
            bit_d = '0;
            byte_d = '0;
         end
         SETUP: if (cnt_q == CW'(SS_SETUP - 1)) begin
            state_d = SHIFT;
            cnt_d = '0;
         end
         SHIFT: if (half_end) begin
            cnt_d = '0;
            sclk_d = ~sclk_q;
            if (!sclk_q) sh_d = {sh_q[38:0], miso};
            else begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = byte_q == 3'd4 ? DONE : GAP;
                  byte_d = byte_q == 3'd4 ? byte_q : byte_q + 3'd1;
               end
            end
         end
         GAP: if (cnt_q == CW'(BYTE_GAP - 1)) begin
            state_d = SHIFT;
            cnt_d = '0;
         end
         DONE: begin
            state_d = IDLE;
            ss_d = 1'b1;
            valid_d = 1'b1;
            x_d = {sh_q[25:24], sh_q[39:32]};
            y_d = {sh_q[9:8], sh_q[23:16]};
            btn_d = sh_q[2:0];
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         poll_q <= PW'(1);
         cnt_q <= '0;
         bit_q <= '0;
         byte_q <= '0;
         sclk_q <= 1'b0;
         ss_q <= 1'b1;
         valid_q <= 1'b0;
         sh_q <= '0;
         x_q <= 10'd512;
         y_q <= 10'd512;
         btn_q <= '0;
      end else begin
         state_q <= state_d;
         poll_q <= poll_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         byte_q <= byte_d;
         sclk_q <= sclk_d;
         ss_q <= ss_d;
         valid_q <= valid_d;
         sh_q <= sh_d;
         x_q <= x_d;
         y_q <= y_d;
         btn_q <= btn_d;
      end
   end
`ifdef JSTK_LED_EN
   logic [39:0] tx_q, tx_d;
   logic        mosi_q, mosi_d;
   // mosi updates one cycle into each low half so it never moves while sclk is high
   always_comb begin
      tx_d = tx_q;
      mosi_d = mosi_q;
      if (state_q == IDLE && tick) tx_d = {6'b100000, led, 32'h0};
      if (state_q == SHIFT && !sclk_q && cnt_q == '0) mosi_d = tx_q[39];
      if (state_q == SHIFT && !sclk_q && half_end) tx_d = {tx_q[38:0], 1'b0};
      if (state_q == DONE) mosi_d = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q <= '0;
         mosi_q <= 1'b0;
      end else begin
         tx_q <= tx_d;
         mosi_q <= mosi_d;
      end
   end
   assign mosi = mosi_q;
`else
   logic unused_led;
   assign unused_led = ^led;
   assign mosi = 1'b0;
`endif
   assign sclk = sclk_q;
   assign ss = ss_q;
   assign busy = ~ss_q;
   assign data_valid = valid_q;
   assign Data_out_X = x_q;
   assign Data_out_Y = y_q;
   assign buttons = btn_q;
endmodule

// File: tb/tb_joystick_spi.sv
// tb_joystick_spi: directed bench for joystick_spi with shortened timing parameters.
module tb_joystick_spi;
   localparam int HALF = 4;
   localparam int SETUP = 16;
   localparam int GAPC = 10;
   localparam int POLL = 300;
   // 16 setup + 40 bits * 8 + 4 gaps * 10 + 1 done cycle
   localparam int TXN = 377;
`ifdef JSTK_LED_EN
   localparam logic [39:0] EMOSI = 40'h8200000000;
`else
   localparam logic [39:0] EMOSI = 40'h0;
`endif
   logic       clk = 1'b0;
   logic       rst, miso, sclk, mosi, ss, data_valid, busy;
   logic [1:0] led;
   logic [9:0] dx, dy;
   logic [2:0] btn;
   logic [39:0] sbits;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int sidx = 0;
   logic prev_sclk = 1'b0;

   joystick_spi #(.HALF_DIV(HALF), .SS_SETUP(SETUP), .BYTE_GAP(GAPC), .POLL_DIV(POLL)) dut (
      .clk(clk), .rst(rst), .miso(miso), .led(led), .sclk(sclk), .mosi(mosi), .ss(ss),
      .Data_out_X(dx), .Data_out_Y(dy), .buttons(btn), .data_valid(data_valid), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // slave: presents the next bit after every sclk fall, restarts whenever ss is high
   always @(negedge clk) begin
      if (ss) sidx = 0;
      else if (prev_sclk && !sclk) sidx = sidx + 1;
      prev_sclk = sclk;
      miso = sidx < 40 ? sbits[39 - sidx] : 1'b0;
   end

   task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ss_fall();
      int n = 0;
      while (ss && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ss_fall_seen", 40'(ss), 40'd0);
   endtask

   // entered at #1 after the edge on which ss fell
   task automatic run_txn(input logic [9:0] ex, input logic [9:0] ey, input logic [2:0] eb,
                          input logic [9:0] px, input logic [9:0] py, input logic [2:0] pb);
      int t = 0, first_rise = -1, rises = 0, lo_run = 1, hi_run = 0;
      int gaps = 0, bad_run = 0, vcount = 0, midchg = 0, mhigh = 0;
      logic prev = 1'b0;
      logic [39:0] mcap = '0;
      while (ss == 1'b0 && t < 1000) begin
         @(posedge clk); #1;
         t++;
         if (sclk && !prev) begin
            rises++;
            mcap = {mcap[38:0], mosi};
            if (rises == 1) first_rise = t;
            else if (lo_run == GAPC + HALF) gaps++;
            else if (lo_run != HALF) bad_run++;
            hi_run = 0;
         end
         if (!sclk && prev) begin
            if (hi_run != HALF) bad_run++;
            lo_run = 0;
         end
         if (sclk) hi_run++;
         else lo_run++;
         prev = sclk;
         if (mosi) mhigh++;
         if (!ss && data_valid) vcount++;
         if (!ss && (dx !== px || dy !== py || btn !== pb)) midchg++;
      end
      chk("ss_low_len", 40'(t), 40'(TXN));
      chk("first_rise", 40'(first_rise), 40'(SETUP + HALF));
      chk("sclk_rises", 40'(rises), 40'd40);
      chk("byte_gaps", 40'(gaps), 40'd4);
      chk("sclk_runs_bad", 40'(bad_run), 40'd0);
      chk("valid_mid", 40'(vcount), 40'd0);
      chk("out_mid_change", 40'(midchg), 40'd0);
      chk("mosi_bytes", mcap, EMOSI);
`ifndef JSTK_LED_EN
      chk("mosi_high_cnt", 40'(mhigh), 40'd0);
`endif
      chk("valid_pulse", 40'(data_valid), 40'd1);
      chk("x_out", 40'(dx), 40'(ex));
      chk("y_out", 40'(dy), 40'(ey));
      chk("buttons", 40'(btn), 40'(eb));
      chk("sclk_idle", 40'(sclk), 40'd0);
      chk("busy_idle", 40'(busy), 40'd0);
      @(posedge clk); #1;
      chk("valid_one_cycle", 40'(data_valid), 40'd0);
   endtask

   initial begin
      int t0, v;
      rst = 1'b1;
      led = 2'b10;
      sbits = 40'h2C03900105;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ss", 40'(ss), 40'd1);
      chk("rst_sclk", 40'(sclk), 40'd0);
      chk("rst_mosi", 40'(mosi), 40'd0);
      chk("rst_busy", 40'(busy), 40'd0);
      chk("rst_valid", 40'(data_valid), 40'd0);
      chk("rst_x", 40'(dx), 40'd512);
      chk("rst_y", 40'(dy), 40'd512);
      chk("rst_btn", 40'(btn), 40'd0);
      rst = 1'b0;
      repeat (POLL - 1) @(posedge clk);
      #1;
      chk("pre_tick_ss", 40'(ss), 40'd1);
      @(posedge clk); #1;
      chk("first_start_ss", 40'(ss), 40'd0);
      chk("first_start_busy", 40'(busy), 40'd1);
      t0 = cyc;
      run_txn(10'd812, 10'd400, 3'b101, 10'd512, 10'd512, 3'b000);
      sbits = 40'hFFFE00FFFA;
      wait_ss_fall();
      chk("dropped_tick_spacing", 40'(cyc - t0), 40'(2 * POLL));
      run_txn(10'd767, 10'd768, 3'b010, 10'd812, 10'd400, 3'b101);
      sbits = 40'h1102220307;
      wait_ss_fall();
      repeat (180) @(posedge clk);
      #1;
      chk("abort_in_byte2", 40'(ss), 40'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_ss", 40'(ss), 40'd1);
      chk("abort_sclk", 40'(sclk), 40'd0);
      chk("abort_x", 40'(dx), 40'd512);
      chk("abort_y", 40'(dy), 40'd512);
      chk("abort_btn", 40'(btn), 40'd0);
      chk("abort_valid", 40'(data_valid), 40'd0);
      rst = 1'b0;
      v = 0;
      repeat (POLL - 1) begin
         @(posedge clk); #1;
         if (data_valid || !ss || dx !== 10'd512) v++;
      end
      chk("abort_quiet", 40'(v), 40'd0);
      @(posedge clk); #1;
      chk("restart_ss", 40'(ss), 40'd0);
      run_txn(10'd529, 10'd802, 3'b111, 10'd512, 10'd512, 3'b000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/joystick_spi.md
JOYSTICK_SPI -- requirements
Module: joystick_spi

Interface
REQ-001 HALF_DIV, 40, clk cycles per SCLK half-period (≈812 kHz at 65 MHz).
REQ-002 SS_SETUP, 1040, clk cycles from SS falling to first SCLK rising edge (16 µs).
REQ-003 BYTE_GAP, 650, clk cycles SCLK idle between bytes (10 µs).
REQ-004 POLL_DIV, 650000, clk cycles between transaction starts (10 ms).
REQ-005 clk  in  1  system clock, one clock domain; all logic on posedge clk.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 miso  in  1  serial data from joystick module.
REQ-008 led  in  2  LED bits sent to joystick (used only with JSTK_LED_EN).
REQ-009 sclk  out  1  SPI clock, mode 0, idle low.
REQ-010 mosi  out  1  SPI data to joystick.
REQ-011 ss  out  1  slave select, active low.
REQ-012 Data_out_X  out  10  latest X position, 0..1023, feeds the movement controller's Data_in_X.
REQ-013 Data_out_Y  out  10  latest Y position, 0..1023, feeds Data_in_Y.
REQ-014 buttons  out  3  latest button bits {trigger, btn2, btn1} = byte4[2:0].
REQ-015 data_valid  out  1  one-cycle pulse when outputs update.
REQ-016 busy  out  1  high from SS assertion until transaction end.

Function
REQ-017 Poll counter SHALL count 0..POLL_DIV-1 free-running and issue a start tick when it wraps to 0.
REQ-018 Start tick in IDLE SHALL move FSM to SETUP; a tick outside IDLE SHALL be dropped, not queued.
REQ-019 States: IDLE (ss=1, busy=0) -> SETUP (ss=0, wait SS_SETUP) -> SHIFT (8 bits) -> GAP (wait BYTE_GAP) -> SHIFT ... -> after 5th byte -> DONE (1 cycle) -> IDLE.
REQ-020 GAP SHALL follow bytes 0..3 only; byte 4 SHALL go straight to DONE.
REQ-021 SHIFT: sclk low HALF_DIV cycles then high HALF_DIV cycles per bit, 8 bits, MSB first.
REQ-022 miso SHALL be sampled on the clk cycle sclk goes high; mosi SHALL change only while sclk is low.
REQ-023 Byte order received: b0=X[7:0], b1[1:0]=X[9:8], b2=Y[7:0], b3[1:0]=Y[9:8], b4[2:0]=buttons; unused bits ignored.
REQ-024 Received bytes SHALL accumulate in a shadow register; Data_out_X/Y and buttons SHALL update together in DONE, never mid-transaction.
REQ-025 data_valid SHALL be high exactly in the cycle after DONE's outputs register, for one cycle.
REQ-026 ss SHALL rise on the cycle FSM enters IDLE from DONE; sclk SHALL be low whenever ss is high.
REQ-027 Bit and byte counters SHALL be 3-bit and 3-bit; byte counter SHALL never exceed 4.

Reset
REQ-028 On rst: FSM=IDLE, ss=1, sclk=0, mosi=0, busy=0, data_valid=0, buttons=0, poll counter=1.
REQ-029 On rst: Data_out_X=512, Data_out_Y=512 (centre, downstream holds position).
REQ-030 rst mid-transaction SHALL abort on the next edge; partial shadow data SHALL be discarded and not reach outputs.

Configuration
REQ-031 Macro JSTK_LED_EN defined: byte0 transmitted SHALL be {6'b100000, led}, led sampled on SETUP entry; bytes1..4 transmit 0x00.
REQ-032 Macro JSTK_LED_EN undefined: mosi SHALL be constant 0 and led SHALL be ignored; receive behaviour unchanged.

Verification
REQ-033 Slave model returns 0x2C,0x03,0x90,0x01,0x05 -> after DONE Data_out_X=812, Data_out_Y=400, buttons=3'b101, one data_valid pulse.
REQ-034 Assert rst -> next edge Data_out_X=Data_out_Y=512, ss=1, sclk=0; first transaction starts POLL_DIV-1 cycles after rst release.
REQ-035 rst asserted during byte 2 -> ss=1 next cycle, outputs stay 512, no data_valid pulse.
REQ-036 Measure one transaction -> SS low to first sclk rise = SS_SETUP + HALF_DIV cycles, 40 sclk rises, 4 gaps of BYTE_GAP, sclk period 2*HALF_DIV.
REQ-037 POLL_DIV set below transaction length -> ticks during busy dropped, transactions back-to-back with IDLE between, no overlap.
REQ-038 JSTK_LED_EN defined, led=2'b10 -> mosi byte0 = 0x82, remaining bytes 0x00; undefined -> mosi 0 throughout.
